// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade scheduler: level encoding and per-channel fade state.
package pwm_pkg;

    localparam int PWM_LEVEL_W     = 8;
    localparam int PWM_MAX         = 254;
    localparam int LEVEL_ALWAYS_ON = 255;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_FADING = 1'b1
    } ch_state_t;

endpackage

// File: rtl/fade_step_unit.sv
// Combinational next-level calculation for one fade step; the step is clamped at the
// target so the level never overshoots in either direction.
module fade_step_unit
    import pwm_pkg::*;
#(
    parameter int LEVEL_W = PWM_LEVEL_W
) (
    input  logic [LEVEL_W-1:0] current,
    input  logic [LEVEL_W-1:0] target,
    input  logic [LEVEL_W-1:0] step,
    output logic [LEVEL_W-1:0] next_level,
    output logic               reached
);

    logic [LEVEL_W-1:0] eff_step;
    logic [LEVEL_W:0]   wide_cur;
    logic [LEVEL_W:0]   wide_tgt;
    logic [LEVEL_W:0]   wide_step;
    logic [LEVEL_W:0]   up_sum;
    logic [LEVEL_W:0]   down_gap;

    always_comb begin
        eff_step  = (step == '0) ? LEVEL_W'(1) : step;
        wide_cur  = {1'b0, current};
        wide_tgt  = {1'b0, target};
        wide_step = {1'b0, eff_step};
        up_sum    = wide_cur + wide_step;
        down_gap  = wide_cur - wide_tgt;
        reached   = (current == target);
        next_level = current;
        if (wide_tgt > wide_cur) begin
            next_level = (up_sum >= wide_tgt) ? target : up_sum[LEVEL_W-1:0];
        end else if (wide_tgt < wide_cur) begin
            // down_gap is only meaningful here, where current > target
            next_level = (wide_step >= down_gap) ? target : current - eff_step;
        end
    end

endmodule

// File: rtl/pwm_fade_scheduler.sv
// Round-robin fade engine: one shared step unit walks every channel toward its target,
// and levels reach the PWM comparators only on period boundaries.
module pwm_fade_scheduler
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int LEVEL_W = PWM_LEVEL_W,
    parameter int RATE_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      period_start,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_ch,
    input  logic [LEVEL_W-1:0]        cmd_target,
    input  logic [LEVEL_W-1:0]        cmd_step,
    input  logic [RATE_W-1:0]         cmd_rate,
    output logic [NUM_CH*LEVEL_W-1:0] level_out,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    logic               cmd_ready_reg;
    logic [1:0]         idx_reg;
    logic               cmd_fire;
    logic [LEVEL_W-1:0] cur_arr  [NUM_CH];
    logic [LEVEL_W-1:0] tgt_arr  [NUM_CH];
    logic [LEVEL_W-1:0] step_arr [NUM_CH];
    logic [LEVEL_W-1:0] sel_cur;
    logic [LEVEL_W-1:0] sel_tgt;
    logic [LEVEL_W-1:0] sel_step;
    logic [LEVEL_W-1:0] sel_next;
    logic               sel_reached;

    // Out-of-range channels are still handshaked so the master never stalls on them
    assign cmd_fire  = cmd_valid && cmd_ready_reg && (int'(cmd_ch) < NUM_CH);
    assign cmd_ready = cmd_ready_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_reg <= 1'b0;
            idx_reg       <= '0;
        end else begin
            cmd_ready_reg <= 1'b1;
            idx_reg       <= (idx_reg == 2'(NUM_CH - 1)) ? 2'd0 : idx_reg + 2'd1;
        end
    end

    always_comb begin
        sel_cur  = '0;
        sel_tgt  = '0;
        sel_step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_reg == 2'(i)) begin
                sel_cur  = cur_arr[i];
                sel_tgt  = tgt_arr[i];
                sel_step = step_arr[i];
            end
        end
    end

    fade_step_unit #(
        .LEVEL_W (LEVEL_W)
    ) u_step (
        .current    (sel_cur),
        .target     (sel_tgt),
        .step       (sel_step),
        .next_level (sel_next),
        .reached    (sel_reached)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [LEVEL_W-1:0] cur_reg;
        logic [LEVEL_W-1:0] tgt_reg;
        logic [LEVEL_W-1:0] step_reg;
        logic [RATE_W-1:0]  rate_reg;
        logic [RATE_W-1:0]  pre_reg;
        logic [LEVEL_W-1:0] level_reg;
        ch_state_t          state_reg;
        logic               done_reg;
        logic               visit;
        logic               load;

        assign visit = (idx_reg == 2'(gi));
        assign load  = cmd_fire && (cmd_ch == 2'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cur_reg   <= '0;
                tgt_reg   <= '0;
                step_reg  <= '0;
                rate_reg  <= '0;
                pre_reg   <= '0;
                level_reg <= '0;
                state_reg <= CH_IDLE;
                done_reg  <= 1'b0;
            end else begin
                done_reg <= 1'b0;
                // Nonblocking read publishes the level as it stood before this cycle's step
                if (period_start) begin
                    level_reg <= cur_reg;
                end
                if (load) begin
                    tgt_reg   <= cmd_target;
                    step_reg  <= cmd_step;
                    rate_reg  <= cmd_rate;
                    pre_reg   <= '0;
                    state_reg <= CH_FADING;
                end else if (visit && state_reg == CH_FADING) begin
                    if (sel_reached) begin
                        state_reg <= CH_IDLE;
                        done_reg  <= 1'b1;
                    end else if (pre_reg == rate_reg) begin
                        pre_reg <= '0;
                        cur_reg <= sel_next;
                    end else begin
                        pre_reg <= pre_reg + 1'b1;
                    end
                end
            end
        end

        assign cur_arr[gi]  = cur_reg;
        assign tgt_arr[gi]  = tgt_reg;
        assign step_arr[gi] = step_reg;
        assign level_out[gi*LEVEL_W +: LEVEL_W] = level_reg;
        assign busy[gi] = (state_reg == CH_FADING);
        assign done[gi] = done_reg;
    end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Directed bench for pwm_fade_scheduler: expected levels, done pulses and busy flags are
// derived by hand from the visit schedule (ch0 on odd clocks, ch1 on even clocks after reset).
module tb_pwm_fade_scheduler;

    localparam int NUM_CH  = 2;
    localparam int LEVEL_W = 8;
    localparam int RATE_W  = 8;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      period_start = 1'b0;
    logic                      cmd_valid = 1'b0;
    logic                      cmd_ready;
    logic [1:0]                cmd_ch = '0;
    logic [LEVEL_W-1:0]        cmd_target = '0;
    logic [LEVEL_W-1:0]        cmd_step = '0;
    logic [RATE_W-1:0]         cmd_rate = '0;
    logic [NUM_CH*LEVEL_W-1:0] level_out;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int e3 = 0;
    int v1 = 0;
    int col_c = 0;
    int cur_c = 0;

    pwm_fade_scheduler #(
        .NUM_CH  (NUM_CH),
        .LEVEL_W (LEVEL_W),
        .RATE_W  (RATE_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .period_start (period_start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ch       (cmd_ch),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_rate     (cmd_rate),
        .level_out    (level_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // cyc = number of clock edges since reset release; ch0 is visited on odd cyc, ch1 on even
    always @(posedge clk) begin
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    endtask

    function automatic int lvl(input int ch);
        return int'(level_out[ch*LEVEL_W +: LEVEL_W]);
    endfunction

    function automatic int odd_upto(input int x);
        return (x + 1) / 2;
    endfunction

    // ch0 during the long fade: 10 -> 255, step 1, rate 0, one step per ch0 visit after e3
    function automatic int cur0(input int t);
        int v;
        v = 10 + odd_upto(t) - odd_upto(e3);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int down_cur(input int t);
        if (t < v1 + 4)  return 200;
        if (t < v1 + 10) return 196;
        if (t < v1 + 16) return 192;
        return 190;
    endfunction

    function automatic int col_cur(input int t);
        if (t < col_c + 4) return cur_c;
        if (t < col_c + 8) return cur_c - 2;
        return cur_c - 3;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue_cmd(input int ch, input int tgt, input int stp, input int rate,
                             output int e);
        cmd_ch     = 2'(ch);
        cmd_target = LEVEL_W'(tgt);
        cmd_step   = LEVEL_W'(stp);
        cmd_rate   = RATE_W'(rate);
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done[ch]) seen = 1'b1;
        end
        check("setup_done_seen", int'(seen), 1);
    endtask

    int up_lvl [11] = '{0, 0, 3, 3, 6, 6, 9, 9, 10, 10, 10};

    initial begin
        int e;
        int t1;
        int t2;
        int pub_val;

        // Reset held with period_start active
        reset_n = 1'b0;
        period_start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_level", int'(level_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 0);
        reset_n = 1'b1;
        #1;
        check("ready_before_clk", int'(cmd_ready), 0);
        @(negedge clk);
        check("ready_after_clk", int'(cmd_ready), 1);

        // Up-fade ch0: 0 -> 10, step 3, rate 0, accepted on edge 2
        issue_cmd(0, 10, 3, 0, e);
        for (int n = 0; n <= 10; n++) begin
            if (n > 0) @(negedge clk);
            check("up_level", lvl(0), up_lvl[n]);
            check("up_busy", int'(busy[0]), (n < 9) ? 1 : 0);
            check("up_done", int'(done[0]), (n == 9) ? 1 : 0);
        end

        // Down-fade ch1 with rate 2 from 200 to 190, step 4
        issue_cmd(1, 200, 255, 0, e);
        wait_done(1);
        issue_cmd(1, 190, 4, 2, e);
        v1 = (e % 2 == 0) ? e + 2 : e + 1;
        for (int t = e + 1; t <= v1 + 20; t++) begin
            @(negedge clk);
            check("down_level", lvl(1), down_cur(t - 1));
            check("down_done", int'(done[1]), (t == v1 + 18) ? 1 : 0);
            check("down_busy", int'(busy[1]), (t < v1 + 18) ? 1 : 0);
        end

        // Glitch-free publish: sparse period_start, first pulse coincides with a ch0 step
        period_start = 1'b0;
        issue_cmd(0, 255, 1, 0, e3);
        t1 = e3 + 20;
        if (t1 % 2 == 0) t1++;
        t2 = t1 + 255;
        pub_val = 10;
        for (int t = e3 + 1; t <= t2 + 5; t++) begin
            period_start = (t == t1) || (t == t2);
            @(negedge clk);
            if (t == t1 || t == t2) pub_val = cur0(t - 1);
            check("pub_level", lvl(0), pub_val);
        end
        check("pub_ch1_hold", lvl(1), 190);

        // Out-of-range channel, then a retarget colliding with ch0's visit
        period_start = 1'b1;
        issue_cmd(3, 0, 1, 0, e);
        check("bad_ch_busy", int'(busy), 1);
        col_c = cyc + 1;
        if (col_c % 2 == 0) col_c++;
        while (cyc + 1 < col_c) @(negedge clk);
        cur_c = cur0(col_c - 1);
        issue_cmd(0, cur_c - 3, 2, 1, e);
        check("col_accept_edge", e, col_c);
        for (int t = col_c + 1; t <= col_c + 12; t++) begin
            @(negedge clk);
            check("col_level", lvl(0), col_cur(t - 1));
            check("col_done", int'(done[0]), (t == col_c + 10) ? 1 : 0);
            check("col_busy", int'(busy[0]), (t < col_c + 10) ? 1 : 0);
        end

        // Async reset between clock edges mid-fade
        issue_cmd(1, 0, 1, 5, e);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", int'(busy[1]), 1);
        check("pre_rst_level_nz", int'(level_out != '0), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_level", int'(level_out), 0);
        check("async_busy", int'(busy), 0);
        check("async_ready", int'(cmd_ready), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
